// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Definitions shared by the ALU and the ALU writeback stage.
//                Contents: datapath widths, opcode encodings, SZCV flag bit
//                positions, branch condition codes, and opcode
//                classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int unsigned c_DATA_W  = 16;
    localparam int unsigned c_REG_AW  = 3;
    localparam int unsigned c_OP_W    = 4;
    localparam int unsigned c_FLAGS_W = 4;
    localparam int unsigned c_COND_W  = 3;

    // SZCV bit positions inside the 4-bit flag vector
    localparam int unsigned c_FLAG_S = 3;
    localparam int unsigned c_FLAG_Z = 2;
    localparam int unsigned c_FLAG_C = 1;
    localparam int unsigned c_FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_CMP  = 4'b0101,
        OP_MOV  = 4'b0110,
        OP_HALT = 4'b1111
    } op_e;

    typedef enum logic [2:0] {
        COND_EQ = 3'b000,   // Z
        COND_LT = 3'b001,   // S ^ V
        COND_LE = 3'b010,   // Z | (S ^ V)
        COND_NE = 3'b011,   // !Z
        COND_AL = 3'b111    // always
    } cond_e;

    // Opcodes 0000..0100 produce a register-file write.
    function automatic logic op_writes_back(input logic [3:0] op);
        return (op <= OP_XOR);
    endfunction

    // Opcodes 0000..0101 (arithmetic/logic and CMP) update the flags.
    function automatic logic op_sets_flags(input logic [3:0] op);
        return (op <= OP_CMP);
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond
//  Description : Combinational branch condition evaluator.
//  Ports       : flags [3:0] in  - SZCV flag vector
//                cond  [2:0] in  - condition select
//                taken       out - condition result
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cond
    import cpu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic w_s;
    logic w_z;
    logic w_v;
    logic w_lt;
    logic w_unused_c;

    assign w_s        = flags[c_FLAG_S];
    assign w_z        = flags[c_FLAG_Z];
    assign w_v        = flags[c_FLAG_V];
    // Carry is not used by any condition code.
    assign w_unused_c = flags[c_FLAG_C];
    // Signed less-than: sign differs from overflow
    assign w_lt       = w_s ^ w_v;

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = w_z;
            COND_LT: taken = w_lt;
            COND_LE: taken = w_z | w_lt;
            COND_NE: taken = ~w_z;
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule : branch_cond
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wb_stage
//  Description : ALU result / writeback stage. Holds one register-file write
//                entry, the architectural SZCV flags, a registered branch
//                condition, a sticky halt indicator and a retired counter.
//  Ports       : clk, rst (sync, active-high)
//                in_valid/in_ready, in_op, in_result, in_szcv, in_rd
//                wb_valid/wb_ready, wb_addr, wb_data
//                flags, cond -> taken, halted, retired
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [15:0] in_result,
    input  logic [3:0]  in_szcv,
    input  logic [2:0]  in_rd,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [3:0]  flags,
    input  logic [2:0]  cond,
    output logic        taken,
    output logic        halted,
    output logic [15:0] retired
);

    logic        r_wb_valid;
    logic [2:0]  r_wb_addr;
    logic [15:0] r_wb_data;
    logic [3:0]  r_flags;
    logic        r_taken;
    logic        r_halted;
    logic [15:0] r_retired;

    logic        w_ready;
    logic        w_accept;
    logic        w_drain;
    logic        w_cond_true;

    // The single writeback slot may be refilled in the same cycle it drains,
    // so a full slot only blocks input while the register file stalls.
    assign w_ready  = ~r_halted & (~r_wb_valid | wb_ready);
    assign w_accept = in_valid & w_ready;
    assign w_drain  = r_wb_valid & wb_ready;

    branch_cond u_branch_cond (
        .flags (r_flags),
        .cond  (cond),
        .taken (w_cond_true)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_flags    <= '0;
            r_taken    <= 1'b0;
            r_halted   <= 1'b0;
            r_retired  <= '0;
        end else begin
            if (w_accept && op_writes_back(in_op)) begin
                r_wb_valid <= 1'b1;
                r_wb_addr  <= in_rd;
                r_wb_data  <= in_result;
            end else if (w_drain) begin
                r_wb_valid <= 1'b0;
            end

            if (w_accept && op_sets_flags(in_op)) begin
                r_flags <= in_szcv;
            end

            // Evaluated from the flags currently held, so a flag update is
            // visible on taken one cycle later.
            r_taken <= w_cond_true;

            if (w_accept && (in_op == OP_HALT)) begin
                r_halted <= 1'b1;
            end

            if (w_accept) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign in_ready = w_ready;
    assign wb_valid = r_wb_valid;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
    assign flags    = r_flags;
    assign taken    = r_taken;
    assign halted   = r_halted;
    assign retired  = r_retired;

endmodule : alu_wb_stage
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_wb_stage
//  Description : Self-checking bench for alu_wb_stage. A transaction-level
//                reference model (queue-based writeback slot, plain flag and
//                counter variables) is stepped alongside the DUT every cycle;
//                directed scenarios add checks against fixed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_result;
    logic [3:0]  in_szcv;
    logic [2:0]  in_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  flags;
    logic [2:0]  cond;
    logic        taken;
    logic        halted;
    logic [15:0] retired;

    always #5 clk = ~clk;

    alu_wb_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_result (in_result),
        .in_szcv   (in_szcv),
        .in_rd     (in_rd),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flags     (flags),
        .cond      (cond),
        .taken     (taken),
        .halted    (halted),
        .retired   (retired)
    );

    int n_tests  = 0;
    int n_fail   = 0;
    int n_writes = 0;

    // Reference model state
    typedef struct {
        bit [2:0]  addr;
        bit [15:0] data;
    } wb_t;

    wb_t       m_wbq[$];
    bit [3:0]  m_flags   = '0;
    bit        m_taken   = 1'b0;
    bit        m_halted  = 1'b0;
    bit [15:0] m_retired = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit cond_true(input bit [3:0] f, input bit [2:0] c);
        bit s;
        bit z;
        bit v;
        s = f[3];
        z = f[2];
        v = f[0];
        case (c)
            3'd0:    return z;
            3'd1:    return s != v;
            3'd2:    return z || (s != v);
            3'd3:    return !z;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input bit v, input bit [3:0] op, input bit [15:0] res,
                         input bit [3:0] szcv, input bit [2:0] rd,
                         input bit wbr, input bit [2:0] c);
        in_valid  = v;
        in_op     = op;
        in_result = res;
        in_szcv   = szcv;
        in_rd     = rd;
        wb_ready  = wbr;
        cond      = c;
    endtask

    // One clock cycle: check in_ready pre-edge, advance model, check outputs.
    task automatic tick();
        bit  ready;
        bit  acc;
        bit  nt;
        wb_t e;
        #1;
        ready = !m_halted && (m_wbq.size() == 0 || wb_ready);
        chk("in_ready", in_ready, ready);
        if (!rst && wb_valid === 1'b1 && wb_ready) n_writes++;
        nt  = cond_true(m_flags, cond);
        acc = in_valid && ready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_wbq.delete();
            m_flags   = '0;
            m_taken   = 1'b0;
            m_halted  = 1'b0;
            m_retired = '0;
        end else begin
            if (m_wbq.size() != 0 && wb_ready) void'(m_wbq.pop_front());
            if (acc && in_op <= 4'd4) begin
                e.addr = in_rd;
                e.data = in_result;
                m_wbq.push_back(e);
            end
            if (acc && in_op <= 4'd5) m_flags = in_szcv;
            m_taken = nt;
            if (acc && in_op == 4'hF) m_halted = 1'b1;
            if (acc) m_retired = m_retired + 16'd1;
        end
        chk("wb_valid", wb_valid, m_wbq.size() != 0);
        if (m_wbq.size() != 0) begin
            chk("wb_addr", wb_addr, m_wbq[0].addr);
            chk("wb_data", wb_data, m_wbq[0].data);
        end
        chk("flags", flags, m_flags);
        chk("taken", taken, m_taken);
        chk("halted", halted, m_halted);
        chk("retired", retired, m_retired);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wb_valid"}, wb_valid, 1'b0);
        chk({tag, "_wb_addr"},  wb_addr,  3'd0);
        chk({tag, "_wb_data"},  wb_data,  16'h0000);
        chk({tag, "_flags"},    flags,    4'b0000);
        chk({tag, "_taken"},    taken,    1'b0);
        chk({tag, "_halted"},   halted,   1'b0);
        chk({tag, "_retired"},  retired,  16'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 4'd0, 3'd0, 1'b1, 3'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int w0;
        bit [3:0] op;

        rst = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 4'd0, 3'd0, 1'b1, 3'd0);
        do_reset();
        chk_reset_outputs("por");
        chk("ready_after_rst", in_ready, 1'b1);

        // ADD 0x1234 -> r3
        drive(1'b1, 4'b0000, 16'h1234, 4'b0000, 3'd3, 1'b1, 3'd0);
        tick();
        chk("add_wb_valid", wb_valid, 1'b1);
        chk("add_wb_addr",  wb_addr,  3'd3);
        chk("add_wb_data",  wb_data,  16'h1234);
        chk("add_retired",  retired,  16'd1);

        // CMP sets Z; taken follows one cycle after flags
        drive(1'b1, 4'b0101, 16'hFFFF, 4'b0100, 3'd6, 1'b1, 3'b000);
        tick();
        chk("cmp_no_wb",    wb_valid, 1'b0);
        chk("cmp_flags",    flags,    4'b0100);
        chk("cmp_taken_c1", taken,    1'b0);
        drive(1'b0, 4'd0, 16'h0, 4'd0, 3'd0, 1'b1, 3'b000);
        tick();
        chk("cmp_taken_c2", taken, 1'b1);

        // Stalled writeback with a second ADD offered, then replacement
        drive(1'b1, 4'b0000, 16'hAAAA, 4'b0000, 3'd1, 1'b0, 3'd0);
        tick();
        drive(1'b1, 4'b0000, 16'hBBBB, 4'b0000, 3'd2, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", in_ready, 1'b0);
            chk("stall_data",  wb_data,  16'hAAAA);
        end
        w0 = n_writes;
        drive(1'b1, 4'b0000, 16'hBBBB, 4'b0000, 3'd2, 1'b1, 3'd0);
        tick();
        chk("replace_valid",  wb_valid, 1'b1);
        chk("replace_data",   wb_data,  16'hBBBB);
        chk("replace_addr",   wb_addr,  3'd2);
        chk("replace_writes", n_writes - w0, 1);
        drive(1'b0, 4'd0, 16'h0, 4'd0, 3'd0, 1'b1, 3'd0);
        tick();

        // Signed compare conditions; MOV must not touch flags
        drive(1'b1, 4'b0001, 16'h0001, 4'b1000, 3'd4, 1'b1, 3'b001);
        tick();
        drive(1'b0, 4'd0, 16'h0, 4'd0, 3'd0, 1'b1, 3'b001);
        tick();
        chk("sub_lt_taken", taken, 1'b1);
        drive(1'b1, 4'b0010, 16'h0002, 4'b0000, 3'd4, 1'b1, 3'b001);
        tick();
        drive(1'b0, 4'd0, 16'h0, 4'd0, 3'd0, 1'b1, 3'b001);
        tick();
        chk("and_lt_taken", taken, 1'b0);
        drive(1'b1, 4'b0110, 16'h0003, 4'b1111, 3'd5, 1'b1, 3'b001);
        tick();
        chk("mov_flags", flags, 4'b0000);

        // HALT offered behind a stalled writeback; accepted as it drains
        do_reset();
        drive(1'b1, 4'b0000, 16'h5555, 4'b0000, 3'd4, 1'b0, 3'd0);
        tick();
        drive(1'b1, 4'b1111, 16'h0, 4'b0000, 3'd0, 1'b0, 3'd0);
        tick();
        chk("halt_blocked_ready",  in_ready, 1'b0);
        chk("halt_blocked_halted", halted,   1'b0);
        w0 = n_writes;
        drive(1'b1, 4'b1111, 16'h0, 4'b0000, 3'd0, 1'b1, 3'd0);
        tick();
        chk("halt_halted", halted,   1'b1);
        chk("halt_ready",  in_ready, 1'b0);
        drive(1'b1, 4'b0000, 16'h6666, 4'b0000, 3'd5, 1'b1, 3'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("halt_writes",   n_writes - w0, 1);
        chk("halt_retired",  retired,  16'd2);
        chk("halt_no_wb",    wb_valid, 1'b0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            op = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, op, 16'($urandom), 4'($urandom),
                  3'($urandom), $urandom_range(0, 9) < 7, 3'($urandom));
            tick();
        end
        rst = 1'b0;

        // Retired counter wrap, then reset with a writeback pending
        do_reset();
        drive(1'b1, 4'b0110, 16'h0, 4'b0000, 3'd0, 1'b1, 3'd0);
        for (int i = 0; i < 65535; i++) tick();
        chk("wrap_ffff", retired, 16'hFFFF);
        tick();
        chk("wrap_0000", retired, 16'h0000);
        drive(1'b1, 4'b0000, 16'h7777, 4'b0000, 3'd5, 1'b0, 3'd0);
        tick();
        chk("pre_rst_valid", wb_valid, 1'b1);
        rst = 1'b1;
        drive(1'b1, 4'b0000, 16'h8888, 4'b1111, 3'd6, 1'b1, 3'd0);
        tick();
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 4'd0, 3'd0, 1'b1, 3'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_wb_stage
`default_nettype wire
